// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
//   Definitions shared by the grayscale, sobel and image sink blocks:
//   FSM state encodings, the pixel width carried by the sobel FIFO, and the
//   default frame geometry.
// -----------------------------------------------------------------------------
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  localparam int PIXEL_WIDTH    = 8;
  localparam int DEF_IMG_WIDTH  = 720;
  localparam int DEF_IMG_HEIGHT = 540;
  localparam int DEF_ADDR_WIDTH = 19;

  // Counter width for a modulo-n count; a 1-deep count still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
//   Column / row / linear address counters walking one frame in raster order.
//
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset, clears all counters
//   clear    in   synchronous clear at the start of a frame
//   advance  in   step to the next pixel
//   col      out  current column
//   row      out  current row
//   addr     out  current linear address, row*IMG_WIDTH+col
//   last     out  combinational, high while pointing at the final pixel
// -----------------------------------------------------------------------------
module raster_counter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int COL_WIDTH  = cnt_width(IMG_WIDTH),
  parameter int ROW_WIDTH  = cnt_width(IMG_HEIGHT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  output logic [COL_WIDTH-1:0]  col,
  output logic [ROW_WIDTH-1:0]  row,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(IMG_HEIGHT - 1);

  assign last = (col == LAST_COL) && (row == LAST_ROW);

  // Stepping past the final pixel folds back to 0 so the address never runs
  // beyond the end of the frame.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (col == LAST_COL) begin
        col  <= '0;
        row  <= row + ROW_WIDTH'(1);
        addr <= addr + ADDR_WIDTH'(1);
      end else begin
        col  <= col + COL_WIDTH'(1);
        addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/image_sink.sv
// -----------------------------------------------------------------------------
// image_sink
//   Drain end of the sobel pipeline. Pops sobel pixels from a first-word-
//   fall-through FIFO and writes them in raster order into the sobel frame
//   memory, one frame of IMG_WIDTH*IMG_HEIGHT pixels per start, then raises
//   done.
//
//   clock             in   rising-edge clock
//   reset             in   synchronous active-high reset
//   start             in   begin a frame (honoured in IDLE and DONE only)
//   fifo_sobel_rd_en  out  FIFO pop, combinational
//   fifo_sobel_dout   in   FIFO head word
//   fifo_sobel_empty  in   FIFO empty
//   mem_wr_en         out  frame memory write strobe
//   mem_addr          out  write address
//   mem_din           out  write data
//   busy              out  high while streaming
//   done              out  high once the frame is complete
//   frame_count       out  completed frames, wraps
//   checksum          out  sum of the frame's pixels mod 2**32
//
//   Build option: define IMAGE_SINK_CHECKSUM_EN to include the checksum
//   accumulator; otherwise checksum is tied to 0.
//
//   state  | meaning
//   IDLE   | waiting for start, FIFO left alone
//   STREAM | popping pixels and writing them to memory
//   DONE   | frame finished, waiting for the next start
// -----------------------------------------------------------------------------
module image_sink
  import sobel_pkg::*;
#(
  parameter int DWIDTH     = PIXEL_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  fifo_sobel_rd_en,
  input  logic [DWIDTH-1:0]     fifo_sobel_dout,
  input  logic                  fifo_sobel_empty,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]     mem_din,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count,
  output logic [31:0]           checksum
);

  localparam int COL_WIDTH = cnt_width(IMG_WIDTH);
  localparam int ROW_WIDTH = cnt_width(IMG_HEIGHT);

  state_t                  state;
  state_t                  next_state;
  logic                    start_frame;
  logic                    pop;
  logic                    last;
  logic [COL_WIDTH-1:0]    col;
  logic [ROW_WIDTH-1:0]    row;
  logic [ADDR_WIDTH-1:0]   addr;

  raster_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .COL_WIDTH  (COL_WIDTH),
    .ROW_WIDTH  (ROW_WIDTH)
  ) u_raster (
    .clock   (clock),
    .reset   (reset),
    .clear   (start_frame),
    .advance (pop),
    .col     (col),
    .row     (row),
    .addr    (addr),
    .last    (last)
  );

  // Only the linear address and last flag are needed here.
  logic unused_ok;
  assign unused_ok = ^{col, row};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The pop is held off during reset so an aborted frame leaves the FIFO
  // exactly as it was.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    pop         = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state  = ST_STREAM;
          start_frame = 1'b1;
        end
      end
      ST_STREAM: begin
        busy = 1'b1;
        pop  = !fifo_sobel_empty && !reset;
        if (pop && last) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          next_state  = ST_STREAM;
          start_frame = 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign fifo_sobel_rd_en = pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      frame_count <= '0;
    end else begin
      mem_wr_en <= pop;
      if (pop) begin
        mem_addr <= addr;
        mem_din  <= fifo_sobel_dout;
      end
      if (pop && last) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

`ifdef IMAGE_SINK_CHECKSUM_EN
  logic [31:0] checksum_acc;

  always_ff @(posedge clock) begin
    if (reset || start_frame) begin
      checksum_acc <= '0;
    end else if (pop) begin
      checksum_acc <= checksum_acc + 32'(fifo_sobel_dout);
    end
  end

  assign checksum = checksum_acc;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_sink.sv
// -----------------------------------------------------------------------------
// tb_image_sink
//   Self-checking bench for image_sink on a 4x3 frame. A queue models the
//   first-word-fall-through sobel FIFO; every memory write is logged and
//   compared against a table of expected {addr, din, done} records.
// -----------------------------------------------------------------------------
module tb_image_sink;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int NPIX = W * H;

  logic          clock;
  logic          reset;
  logic          start;
  logic          fifo_sobel_rd_en;
  logic [DW-1:0] fifo_sobel_dout;
  logic          fifo_sobel_empty;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          busy;
  logic          done;
  logic [15:0]   frame_count;
  logic [31:0]   checksum;

  image_sink #(
    .DWIDTH     (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .fifo_sobel_rd_en (fifo_sobel_rd_en),
    .fifo_sobel_dout  (fifo_sobel_dout),
    .fifo_sobel_empty (fifo_sobel_empty),
    .mem_wr_en        (mem_wr_en),
    .mem_addr         (mem_addr),
    .mem_din          (mem_din),
    .busy             (busy),
    .done             (done),
    .frame_count      (frame_count),
    .checksum         (checksum)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          done;
  } wr_vec_t;

  wr_vec_t       exp_tab [NPIX];
  logic [DW-1:0] q[$];
  logic          stall;

  logic [AW-1:0] log_addr [64];
  logic [DW-1:0] log_din  [64];
  logic          log_done [64];
  int            n_wr;
  int            pops;
  int            gap_rd_cnt;
  int            gap_wr_cnt;
  int            rd_empty_cnt;
  int            pass_cnt;
  int            total_cnt;
  bit            finished;
  logic [31:0]   exp_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic refresh();
    fifo_sobel_empty = stall || (q.size() == 0);
    fifo_sobel_dout  = (q.size() > 0) ? q[0] : '0;
  endtask

  // One clock: sample the pop request before the edge, apply it to the FIFO
  // model after the edge, and log any memory write seen after the edge.
  task automatic tick();
    logic pop;
    logic was_stall;
    #2;
    pop       = fifo_sobel_rd_en;
    was_stall = stall;
    if (pop && fifo_sobel_empty) rd_empty_cnt++;
    if (pop && was_stall) gap_rd_cnt++;
    @(posedge clock);
    #1;
    if (pop && q.size() > 0) begin
      q.delete(0);
      pops++;
    end
    if (mem_wr_en) begin
      if (was_stall) gap_wr_cnt++;
      if (n_wr < 64) begin
        log_addr[n_wr] = mem_addr;
        log_din[n_wr]  = mem_din;
        log_done[n_wr] = done;
      end
      n_wr++;
    end
    refresh();
  endtask

  // Start a frame and stream until done, or until abort_at pops have gone.
  task automatic run_frame(input int stall_at, input int abort_at,
                           input int start_at, input bit hold_start);
    int stall_left;
    n_wr       = 0;
    pops       = 0;
    gap_rd_cnt = 0;
    gap_wr_cnt = 0;
    stall_left = 5;
    finished   = 0;
    start = 1'b1;
    refresh();
    tick();
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (abort_at >= 0 && pops >= abort_at) break;
      start = (hold_start && cyc < 2) || (pops == start_at);
      stall = (pops == stall_at) && (stall_left > 0);
      if (stall) stall_left--;
      refresh();
      tick();
      if (done) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    refresh();
  endtask

  task automatic compare_frame(input string tag);
    check({tag, " finished"}, 32'(finished), 32'd1);
    check({tag, " write count"}, n_wr, NPIX);
    for (int i = 0; i < NPIX; i++) begin
      check($sformatf("%s wr%0d addr", tag, i), 32'(log_addr[i]), 32'(exp_tab[i].addr));
      check($sformatf("%s wr%0d din", tag, i), 32'(log_din[i]), 32'(exp_tab[i].din));
      check($sformatf("%s wr%0d done", tag, i), 32'(log_done[i]), 32'(exp_tab[i].done));
    end
  endtask

  task automatic fill_table(input int base, input int split, input int base2);
    exp_sum = '0;
    for (int i = 0; i < NPIX; i++) begin
      exp_tab[i].addr = AW'(i);
      exp_tab[i].din  = (i < split) ? DW'(base + i) : DW'(base2 + i);
      exp_tab[i].done = (i == NPIX - 1);
      exp_sum = exp_sum + 32'(exp_tab[i].din);
    end
`ifndef IMAGE_SINK_CHECKSUM_EN
    exp_sum = '0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rd_empty_cnt = 0;
    n_wr         = 0;
    pops         = 0;
    reset        = 1'b1;
    start        = 1'b0;
    stall        = 1'b0;
    q.push_back(8'hAA);
    refresh();

    // Reset and idle with a non-empty FIFO
    repeat (3) tick();
    reset = 1'b0;
    refresh();
    #1;
    check("reset mem_wr_en", 32'(mem_wr_en), 0);
    check("reset mem_addr", 32'(mem_addr), 0);
    check("reset mem_din", 32'(mem_din), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset frame_count", 32'(frame_count), 0);
    check("reset checksum", checksum, 0);
    check("reset rd_en", 32'(fifo_sobel_rd_en), 0);
    repeat (3) tick();
    check("idle no pop", q.size(), 1);
    check("idle no write", n_wr, 0);
    q.delete();
    refresh();

    // Frame 1: FIFO never empty, data equals address
    for (int i = 0; i < NPIX; i++) q.push_back(DW'(i));
    fill_table(0, NPIX, 0);
    run_frame(-1, -1, -1, 1'b0);
    compare_frame("f1");
    check("f1 frame_count", 32'(frame_count), 1);
    check("f1 busy at done", 32'(busy), 0);
    check("f1 checksum", checksum, exp_sum);

    // DONE holds without start and leaves the FIFO alone
    for (int i = 0; i < NPIX; i++) q.push_back(DW'(100 + i));
    refresh();
    n_wr = 0;
    repeat (3) tick();
    check("done hold", 32'(done), 1);
    check("done hold no pop", q.size(), NPIX);
    check("done hold no write", n_wr, 0);
    check("done hold checksum", checksum, exp_sum);

    // Frame 2: start held into STREAM, start pulsed mid-frame, 5-cycle gap
    fill_table(100, NPIX, 100);
    run_frame(6, -1, 3, 1'b1);
    compare_frame("f2");
    check("f2 gap rd_en", gap_rd_cnt, 0);
    check("f2 gap mem_wr_en", gap_wr_cnt, 0);
    check("f2 resume addr", 32'(log_addr[6]), 6);
    check("f2 frame_count", 32'(frame_count), 2);

    // Frame 3: reset after 7 pops
    for (int i = 0; i < NPIX; i++) q.push_back(DW'(150 + i));
    refresh();
    run_frame(-1, 7, -1, 1'b0);
    check("abort pops", pops, 7);
    reset = 1'b1;
    #1;
    check("abort rd_en under reset", 32'(fifo_sobel_rd_en), 0);
    tick();
    reset = 1'b0;
    refresh();
    #1;
    check("abort mem_wr_en", 32'(mem_wr_en), 0);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort frame_count", 32'(frame_count), 0);
    check("abort fifo left", q.size(), 5);

    // Restart after abort: leftover pixels land at address 0 onward
    for (int i = 0; i < NPIX; i++) q.push_back(DW'(200 + i));
    fill_table(157, 5, 195);
    run_frame(-1, -1, -1, 1'b0);
    compare_frame("f4");
    check("f4 frame_count", 32'(frame_count), 1);
    check("f4 checksum", checksum, exp_sum);
    q.delete();
    refresh();

    // Frame 5: all pixels 0xFF
    for (int i = 0; i < NPIX; i++) q.push_back(8'hFF);
    fill_table(0, NPIX, 0);
    for (int i = 0; i < NPIX; i++) exp_tab[i].din = 8'hFF;
`ifdef IMAGE_SINK_CHECKSUM_EN
    exp_sum = 32'h0000_0BF4;
`else
    exp_sum = 32'h0;
`endif
    run_frame(-1, -1, -1, 1'b0);
    compare_frame("f5");
    check("f5 checksum", checksum, exp_sum);
    repeat (2) tick();
    check("f5 checksum stable", checksum, exp_sum);
    check("f5 frame_count", 32'(frame_count), 2);
    check("rd_en on empty", rd_empty_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
